bias_act_stage: RTL and testbench

- Post-accumulation stage of the conv layer, directly downstream of the per-channel bias ROM.
- Sequences output channels and drives the ROM's load strobe and channel index (c_load/cout). Accepts the channel's bias byte one cycle later.
- Adds the bias to each incoming convolution accumulator, applies ReLU, right-shifts to requantize, and saturates to 8 bits.
- Emits the results through a valid/ready stream to the pooling/writeback stage.

---
 rtl/bias_act_stage_pkg.sv | 10 +
 rtl/bias_act_stage_requant_sat.sv | 22 ++
 rtl/bias_act_stage.sv | 109 ++++++++++
 tb/tb_bias_act_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_act_stage_pkg.sv
// bias_act_stage_pkg: shared conv-layer defaults, activation ceiling and FSM encoding.
// Used by bias_act_stage and requant_sat.
package bias_act_stage_pkg;
  localparam int ACC_W_DEF = 20;
  localparam int OC_DEF = 7;
  localparam int PIX_DEF = 675;
  localparam int SHIFT_DEF = 7;
  localparam logic [7:0] ACT_MAX = 8'd127;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_FLUSH} state_e;
endpackage

// File: rtl/bias_act_stage_requant_sat.sv
// requant_sat: combinational ReLU, right-shift requantize, optional round, clamp to 0..127.
// Ports: sum (ACC_W+1 bit signed biased accumulator) -> q (8-bit activation).
// Build option: define BIAS_ACT_ROUND_EN for round-half-up, otherwise truncation.
module requant_sat
  import bias_act_stage_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic [ACC_W:0] sum,
  output logic [7:0]     q
);
`ifdef BIAS_ACT_ROUND_EN
  localparam logic [ACC_W+1:0] RND = (ACC_W+2)'(1) << (SHIFT - 1);
`else
  localparam logic [ACC_W+1:0] RND = '0;
`endif
  logic [ACC_W+1:0] sh;
  // One extra bit keeps the rounding add from overflowing; only used when sum > 0.
  assign sh = ({sum[ACC_W], sum} + RND) >> SHIFT;
  assign q = (sum[ACC_W] || sum == '0) ? '0 : (|sh[ACC_W+1:7]) ? ACT_MAX : {1'b0, sh[6:0]};
endmodule

// File: rtl/bias_act_stage.sv
// bias_act_stage: channel sequencer + 2-stage bias add / ReLU / requantize / saturate pipeline.
// Ports: clk, rst (async active-low), start; acc/in_valid/in_ready input stream;
//        c_load/cout drive the bias ROM, bias returns the cycle after c_load;
//        out_data/out_ch/out_valid/out_ready output stream; busy, done status.
// Build option: BIAS_ACT_ROUND_EN selects round-half-up requantization.
module bias_act_stage
  import bias_act_stage_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OC = OC_DEF,
  parameter int PIX = PIX_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ACC_W-1:0] acc,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             c_load,
  output logic [3:0]       cout,
  input  logic [7:0]       bias,
  output logic [7:0]       out_data,
  output logic [3:0]       out_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);
  localparam int PW = $clog2(PIX + 2);
  state_e state_q, state_d;
  logic [3:0] cout_q, cout_d, s1_ch_q, s1_ch_d, out_ch_q, out_ch_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [ACC_W:0] s1_sum_q, s1_sum_d;
  logic [7:0] out_data_q, out_data_d, q;
  logic s1_valid_q, s1_valid_d, out_valid_q, out_valid_d, done_q, done_d;
  logic advance, hs, last, last_ch;

  requant_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_requant (.sum(s1_sum_q), .q(q));

  always_comb begin
    advance = !out_valid_q || out_ready;
    in_ready = state_q == ST_RUN && advance;
    hs = in_valid && in_ready;
    last = hs && pix_cnt_q == PW'(PIX);
    last_ch = cout_q == 4'(OC);
    state_d = state_q;
    cout_d = cout_q;
    pix_cnt_d = hs ? (last ? '0 : pix_cnt_q + PW'(1)) : pix_cnt_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_LOAD;
        cout_d = '0;
        pix_cnt_d = '0;
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: if (last) begin
        state_d = last_ch ? ST_FLUSH : ST_LOAD;
        cout_d = last_ch ? cout_q : cout_q + 4'd1;
      end
      default: if (!s1_valid_q && !out_valid_q) begin
        state_d = ST_IDLE;
        done_d = 1'b1;
      end
    endcase
    // Bias is folded in at stage 1, so a ROM reload never touches in-flight samples.
    s1_valid_d = advance ? hs : s1_valid_q;
    s1_sum_d = advance ? {acc[ACC_W-1], acc} + {{(ACC_W-7){bias[7]}}, bias} : s1_sum_q;
    s1_ch_d = advance ? cout_q : s1_ch_q;
    out_valid_d = advance ? s1_valid_q : out_valid_q;
    out_data_d = advance ? (s1_valid_q ? q : '0) : out_data_q;
    out_ch_d = advance ? s1_ch_q : out_ch_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cout_q <= '0;
      pix_cnt_q <= '0;
      done_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_sum_q <= '0;
      s1_ch_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_ch_q <= '0;
    end else begin
      state_q <= state_d;
      cout_q <= cout_d;
      pix_cnt_q <= pix_cnt_d;
      done_q <= done_d;
      s1_valid_q <= s1_valid_d;
      s1_sum_q <= s1_sum_d;
      s1_ch_q <= s1_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_ch_q <= out_ch_d;
    end
  end

  assign c_load = state_q == ST_LOAD;
  assign busy = state_q != ST_IDLE;
  assign cout = cout_q;
  assign done = done_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_ch = out_ch_q;
endmodule

// File: tb/tb_bias_act_stage.sv
// tb_bias_act_stage: table-driven + randomized scoreboard bench for bias_act_stage (OC=1, PIX=3).
module tb_bias_act_stage;
  localparam int ACC_W = 20;
  localparam int OC = 1;
  localparam int PIX = 3;
  localparam int SHIFT = 7;
  localparam int N = (OC + 1) * (PIX + 1);
`ifdef BIAS_ACT_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  typedef struct {int d; int c;} exp_t;
  typedef struct {int a; int b; int e;} vec_t;

  logic clk, rst, start, in_valid, in_ready, c_load, out_valid, out_ready, busy, done;
  logic [ACC_W-1:0] acc;
  logic [3:0] cout, out_ch;
  logic [7:0] bias, out_data;
  logic [7:0] rom [16];
  int n_checks, n_fail, done_cnt, hold, bp_mode;
  int cl_q[$];
  exp_t exp_q[$];
  int job_a[N], job_e[N];
  vec_t tab[14];
  logic st;
  logic [7:0] hd;
  logic [3:0] hc;

  bias_act_stage #(.ACC_W(ACC_W), .OC(OC), .PIX(PIX), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .start(start), .acc(acc), .in_valid(in_valid), .in_ready(in_ready),
    .c_load(c_load), .cout(cout), .bias(bias), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_q(input int a, input int b);
    int s, q;
    s = a + b;
    if (s <= 0) return 0;
    q = (s + (RND != 0 ? (1 << (SHIFT - 1)) : 0)) / (1 << SHIFT);
    return q > 127 ? 127 : q;
  endfunction

  // One clock step: the bias ROM answers the cycle after c_load; out_ready follows the backpressure mode.
  task automatic tick();
    logic cl;
    logic [3:0] cc;
    cl = c_load;
    cc = cout;
    @(posedge clk);
    #1;
    if (cl) bias = rom[cc];
    out_ready = hold > 0 ? 1'b0 : (bp_mode != 0 ? ($urandom_range(0, 3) != 0) : 1'b1);
    if (hold > 0) hold--;
  endtask

  task automatic send(input int a, input int e, input int ch, output int t);
    exp_t x;
    acc = a[ACC_W-1:0];
    in_valid = 1'b1;
    t = 1;
    @(negedge clk);
    while (!in_ready && t < 400) begin
      tick();
      @(negedge clk);
      t++;
    end
    if (in_ready) begin
      x.d = e;
      x.c = ch;
      exp_q.push_back(x);
    end else chk("in_ready_timeout", t, 0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_out_ch"}, int'(out_ch), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_c_load"}, int'(c_load), 0);
    chk({tag, "_cout"}, int'(cout), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  // mode 0: plain, 1: sequencing/start-ignore checks, 2: 5-cycle output stall mid-stream
  task automatic job(input int mode);
    int tt[N];
    int t;
    cl_q.delete();
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (mode == 1) begin
      chk("load_strobe", int'(c_load), 1);
      chk("load_cout", int'(cout), 0);
      chk("load_in_ready", int'(in_ready), 0);
      chk("busy_after_start", int'(busy), 1);
    end
    for (int k = 0; k < N; k++) begin
      if (mode == 2 && k == 3) begin
        hold = 5;
        tick();
      end
      if (mode == 1 && k == 3) start = 1'b1;
      send(job_a[k], job_e[k], k / (PIX + 1), tt[k]);
      start = 1'b0;
    end
    if (mode == 1) begin
      chk("busy_in_flush", int'(busy), 1);
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    t = 0;
    while (done_cnt == 0 && t < 400) begin
      tick();
      t++;
    end
    chk("done_seen", done_cnt, 1);
    chk("drained_at_done", exp_q.size(), 0);
    repeat (3) tick();
    chk("done_once", done_cnt, 1);
    chk("busy_after_done", int'(busy), 0);
    chk("c_load_count", cl_q.size(), OC + 1);
    for (int c = 0; c < cl_q.size(); c++) chk("c_load_cout", cl_q[c], c);
    if (mode == 1) begin
      chk("first_in_ready", tt[0], 2);
      chk("bubble_at_boundary", tt[PIX + 1], 2);
      chk("no_bubble_in_channel", tt[PIX + 2], 1);
    end
    if (mode == 2) chk("bp_in_ready_held", int'(tt[3] >= 4), 1);
  endtask

  task automatic rand_fill();
    for (int c = 0; c <= OC; c++) rom[c] = 8'($urandom);
    for (int k = 0; k < N; k++) begin
      job_a[k] = $urandom_range(0, 3) == 0 ? int'($signed(20'($urandom))) : int'($urandom_range(0, 40000)) - 20000;
      job_e[k] = ref_q(job_a[k], int'($signed(rom[k / (PIX + 1)])));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) st = 1'b0;
    else begin
      if (st) begin
        chk("stall_hold_valid", int'(out_valid), 1);
        chk("stall_hold_data", int'(out_data), int'(hd));
        chk("stall_hold_ch", int'(out_ch), int'(hc));
      end
      st = out_valid && !out_ready;
      hd = out_data;
      hc = out_ch;
      if (st) chk("stall_in_ready", int'(in_ready), 0);
      if (c_load) cl_q.push_back(int'(cout));
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", exp_q.size(), 1);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", int'(out_data), e.d);
          chk("out_ch", int'(out_ch), e.c);
        end
      end
    end
  end

  initial begin
    int t;
    n_checks = 0;
    n_fail = 0;
    done_cnt = 0;
    hold = 0;
    bp_mode = 0;
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    acc = '0;
    bias = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) rom[c] = '0;
    tab[0] = '{1000, 24, 8};
    tab[1] = '{-500, 10, 0};
    tab[2] = '{20000, 0, 127};
    tab[3] = '{-128, 127, 0};
    tab[4] = '{192, 0, RND != 0 ? 2 : 1};
    tab[5] = '{191, 0, 1};
    tab[6] = '{0, 0, 0};
    tab[7] = '{128, 0, 1};
    tab[8] = '{-200, -128, 0};
    tab[9] = '{16383, 0, 127};
    tab[10] = '{524287, 127, 127};
    tab[11] = '{-524288, -128, 0};
    tab[12] = '{64, 0, RND};
    tab[13] = '{127, 0, RND};

    repeat (3) tick();
    chk_idle("reset");
    rst = 1'b1;
    tick();

    rand_fill();
    job(1);
    rand_fill();
    job(2);

    for (int i = 0; i < 14; i++) begin
      for (int c = 0; c <= OC; c++) rom[c] = 8'(tab[i].b);
      for (int k = 0; k < N; k++) begin
        job_a[k] = tab[i].a;
        job_e[k] = tab[i].e;
      end
      job(0);
    end

    bp_mode = 1;
    repeat (10) begin
      rand_fill();
      job(0);
    end
    bp_mode = 0;

    rand_fill();
    start = 1'b1;
    tick();
    start = 1'b0;
    send(job_a[0], job_e[0], 0, t);
    send(job_a[1], job_e[1], 0, t);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_idle("mid_reset");
    tick();
    rst = 1'b1;
    done_cnt = 0;
    cl_q.delete();
    repeat (10) tick();
    chk("no_done_after_reset", done_cnt, 0);
    chk("no_load_after_reset", cl_q.size(), 0);
    chk("idle_after_reset", int'(busy), 0);

    rand_fill();
    job(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
